pcm_to_i2s_tx: RTL
==================

Name: pcm_to_i2s_tx

Overview:
Downstream output stage of the beamformer. Accepts summed stereo PCM pairs over a valid/ready handshake and buffers them in a small FIFO. Each pair is scaled to the output word width and serialized as a standard I2S frame (MSB first, one-bit delay after WS edge) at one bit per clk. Replaces the ad-hoc shift-out of the summed word and drives the external DAC/MCU pins.

Parameters:
IN_BITS, 20, width of signed input samples (beamformer sum, with headroom)
OUT_BITS, 16, width of serialized signed word; OUT_BITS <= SLOT_BITS
SLOT_BITS, 16, clk cycles per channel half-frame; frame = 2*SLOT_BITS cycles
GAIN_SHIFT, 2, arithmetic right shift applied before width reduction
FIFO_DEPTH, 4, stereo pairs buffered; power of two, >= 2

Ports:
clk  in  1  clock, one serial bit per cycle
reset  in  1  synchronous, active-high
in_valid  in  1  input pair valid
in_ready  out  1  FIFO can accept a pair
in_left  in  IN_BITS  signed left sample
in_right  in  IN_BITS  signed right sample
ws  out  1  word select; 0 = left, 1 = right
sd  out  1  serial data, registered
frame_start  out  1  one-cycle pulse at bit_cnt == 0
underrun  out  1  sticky; set when a frame starts with the FIFO empty
underrun_clr  in  1  clears underrun
fifo_level  out  $clog2(FIFO_DEPTH+1)  stored pairs

Behaviour:
- Reset (clk is the only clock, reset is synchronous active-high): bit_cnt=0, ws=0, sd=0, FIFO empty, fifo_level=0, in_ready=1, underrun=0, active left/right words=0.
- bit_cnt is free-running, 0..2*SLOT_BITS-1, then wraps to 0. ws = (bit_cnt >= SLOT_BITS), decoded combinationally from the registered counter. frame_start = (bit_cnt == 0).
- Conversion on push: w = in >>> GAIN_SHIFT (sign-preserving). Store w[OUT_BITS-1:0] (wrap). Saturation behaviour is covered under Optional Feature.
- Push: occurs when in_valid && in_ready. in_ready = (fifo_level < FIFO_DEPTH). A push is refused when full, even if a pop happens in the same cycle.
- Pop: occurs at the cycle with bit_cnt == 2*SLOT_BITS-1. If the FIFO is non-empty, the head pair loads into the active registers at the end of that cycle. If empty, the active registers load 0 and underrun is set. There is no push-to-pop bypass: a push in the same cycle as a pop on an empty FIFO is stored and still counts as an underrun.
- Simultaneous push and pop with 0 < level < FIFO_DEPTH: level unchanged.
- Serializer: the bit selected at bit_cnt=j:
  - j < SLOT_BITS: left[OUT_BITS-1-j] if j < OUT_BITS, else 0.
  - j >= SLOT_BITS: right[OUT_BITS-1-(j-SLOT_BITS)] with the same padding rule.
  - sd registers the selected bit, so it lags one cycle. The left MSB appears on sd at bit_cnt=1 (one cycle after ws falls). The right LSB of frame N appears on sd at bit_cnt=0 of frame N+1.
- underrun clears on underrun_clr unless a new underrun event occurs in the same cycle; set wins.
- Reset mid-frame: abandons the current frame. sd=0 and ws=0 on the next cycle; FIFO contents are discarded.

Optional Feature:
SATURATE_EN defined: after the shift, w is clamped to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1] before storing. For example, 0x1FFFF becomes 0x7FFF.
SATURATE_EN not defined: low OUT_BITS of w are kept (two's-complement wrap). No extra logic.
fifo_level, handshake and timing are identical in both builds.

Test Plan:
(Defaults for all scenarios.)
1. Reset, push L=20'h12344, R=20'hFFFFC before the first pop -> next frame: sd at bit_cnt 1..16 = 0x48D1 MSB first; at bit_cnt 17..31 then 0 of the following frame = 0xFFFF; ws low for cycles 0..15, high for 16..31.
2. No pushes after reset -> sd constant 0; underrun=1 from the first pop cycle onward; pulse underrun_clr -> 0, then set again at the next frame boundary.
3. Push 5 pairs on consecutive cycles mid-frame -> in_ready drops after the 4th; fifo_level=4; 5th accepted only after the pop at bit_cnt=31; level stays 4.
4. Push L=20'h7FFFF, R=20'h80000 -> without SATURATE_EN: serialized 0xFFFF / 0x0000; with SATURATE_EN: 0x7FFF / 0x8000.
5. Push 2 pairs, assert reset for 1 cycle at bit_cnt=9 -> after release: bit_cnt=0, fifo_level=0, sd=0, underrun raised at the next frame end.
6. Push and pop in the same cycle with level=2 -> level stays 2; order preserved (pairs emerge FIFO order, checked by distinct values 0x00004, 0x00008, 0x0000C).

Source files
------------

// File: rtl/pcm_to_i2s_tx.sv
// pcm_to_i2s_tx: output stage of the beamformer.
// Stereo PCM pairs are accepted over a valid/ready handshake and scaled to
// OUT_BITS on entry. They are held in a small FIFO and sent out as standard
// I2S frames, one bit per clk: MSB first, with the data delayed one bit after
// each WS edge.
// Build option: define SATURATE_EN to clamp scaled samples to the OUT_BITS
// range. Without it the low OUT_BITS bits are kept (two's-complement wrap).
module pcm_to_i2s_tx #(
    parameter int IN_BITS    = 20,
    parameter int OUT_BITS   = 16,
    parameter int SLOT_BITS  = 16,
    parameter int GAIN_SHIFT = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [IN_BITS-1:0]            in_left,
    input  logic signed [IN_BITS-1:0]            in_right,
    output logic                                 ws,
    output logic                                 sd,
    output logic                                 frame_start,
    output logic                                 underrun,
    input  logic                                 underrun_clr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W      = $clog2(OUT_BITS);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0] CNT_OUT  = CNT_W'(OUT_BITS);
    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [OUT_BITS-1:0] WORD_ZERO = {OUT_BITS{1'b0}};
    localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(OUT_BITS - 1);

`ifdef SATURATE_EN
    localparam logic signed [IN_BITS-1:0] SAT_MAX = IN_BITS'((64'sd1 <<< (OUT_BITS - 1)) - 64'sd1);
    localparam logic signed [IN_BITS-1:0] SAT_MIN = ~SAT_MAX;
`endif

    // Gain shift (sign-preserving) followed by reduction to OUT_BITS.
    function automatic logic [OUT_BITS-1:0] scale_sample(input logic signed [IN_BITS-1:0] s);
`ifdef SATURATE_EN
        logic signed [IN_BITS-1:0] w;
        w = s >>> GAIN_SHIFT;
        if (w > SAT_MAX) begin
            scale_sample = SAT_MAX[OUT_BITS-1:0];
        end else if (w < SAT_MIN) begin
            scale_sample = SAT_MIN[OUT_BITS-1:0];
        end else begin
            scale_sample = w[OUT_BITS-1:0];
        end
`else
        scale_sample = OUT_BITS'(s >>> GAIN_SHIFT);
`endif
    endfunction

    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OUT_BITS-1:0] act_l_q, act_l_d;
    logic [OUT_BITS-1:0] act_r_q, act_r_d;
    logic                sd_q, sd_d;
    logic                und_q, und_d;
    logic [OUT_BITS-1:0] mem_l_q [FIFO_DEPTH];
    logic [OUT_BITS-1:0] mem_r_q [FIFO_DEPTH];

    logic                in_ready_s;
    logic                push_s;
    logic                pop_slot_s;
    logic                pop_s;
    logic                und_evt_s;
    logic [CNT_W-1:0]    pos_s;
    logic [OUT_BITS-1:0] word_s;
    logic [BIT_W-1:0]    idx_s;

    assign in_ready_s  = (level_q < LVL_FULL);
    assign in_ready    = in_ready_s;
    assign ws          = (bit_cnt_q >= CNT_SLOT);
    assign frame_start = (bit_cnt_q == CNT_ZERO);
    assign sd          = sd_q;
    assign underrun    = und_q;
    assign fifo_level  = level_q;

    // Handshake and frame-boundary events.
    always_comb begin
        push_s     = in_valid && in_ready_s;
        pop_slot_s = (bit_cnt_q == CNT_LAST);
        pop_s      = pop_slot_s && (level_q != LVL_ZERO);
        und_evt_s  = pop_slot_s && (level_q == LVL_ZERO);
    end

    // Next state for the counter, the FIFO bookkeeping, the active words and underrun.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        level_d   = level_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        act_l_d   = act_l_q;
        act_r_d   = act_r_q;
        und_d     = und_q;

        if (pop_slot_s) begin
            bit_cnt_d = CNT_ZERO;
        end else begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // An empty FIFO at the frame boundary sends a silent frame; pushes
        // landing in that same cycle are stored, never bypassed.
        if (pop_s) begin
            act_l_d = mem_l_q[rd_ptr_q];
            act_r_d = mem_r_q[rd_ptr_q];
        end else if (pop_slot_s) begin
            act_l_d = WORD_ZERO;
            act_r_d = WORD_ZERO;
        end else begin
            act_l_d = act_l_q;
            act_r_d = act_r_q;
        end

        // A new underrun event takes priority over a clear in the same cycle.
        if (und_evt_s) begin
            und_d = 1'b1;
        end else if (underrun_clr) begin
            und_d = 1'b0;
        end else begin
            und_d = und_q;
        end
    end

    // Serializer bit select: the position within the slot picks the bit MSB first, padding past OUT_BITS.
    always_comb begin
        pos_s  = bit_cnt_q;
        word_s = act_l_q;
        idx_s  = BIT_MSB;
        sd_d   = 1'b0;
        if (bit_cnt_q >= CNT_SLOT) begin
            pos_s  = bit_cnt_q - CNT_SLOT;
            word_s = act_r_q;
        end else begin
            pos_s  = bit_cnt_q;
            word_s = act_l_q;
        end
        idx_s = BIT_MSB - pos_s[BIT_W-1:0];
        if (pos_s < CNT_OUT) begin
            sd_d = word_s[idx_s];
        end else begin
            sd_d = 1'b0;
        end
    end

    // Control and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q <= CNT_ZERO;
            level_q   <= LVL_ZERO;
            wr_ptr_q  <= PTR_ZERO;
            rd_ptr_q  <= PTR_ZERO;
            act_l_q   <= WORD_ZERO;
            act_r_q   <= WORD_ZERO;
            sd_q      <= 1'b0;
            und_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            level_q   <= level_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            act_l_q   <= act_l_d;
            act_r_q   <= act_r_d;
            sd_q      <= sd_d;
            und_q     <= und_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_l_q[wr_ptr_q] <= scale_sample(in_left);
            mem_r_q[wr_ptr_q] <= scale_sample(in_right);
        end
    end

endmodule
